// File: rtl/adc_pwr_pkg.sv
// ---------------------------------------------------------------------------
// adc_pwr_pkg
// Shared definitions for the ADC power/conversion sequencer:
//   - state_e  : 3-bit sequencer state encoding, also driven out on state_o
//   - MODE_*   : pwr_mode policy encodings
//   - mode_is_low / mode_is_mod : policy decode helpers
// ---------------------------------------------------------------------------
package adc_pwr_pkg;

    // Save and restore are never needed at the same time, so they share one
    // retention state (ST_RET). A direction flag in the sequencer selects
    // which pulse is issued. This keeps the whole state space in 3 bits.
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RET   = 3'd2,
        ST_UNISO = 3'd3,
        ST_IDLE  = 3'd4,
        ST_CONV  = 3'd5,
        ST_POST  = 3'd6,
        ST_ISO   = 3'd7
    } state_e;

    localparam logic [1:0] MODE_LOW  = 2'b00;
    localparam logic [1:0] MODE_MOD  = 2'b01;
    localparam logic [1:0] MODE_HIGH = 2'b10;   // 2'b11 also decodes as HIGH

    function automatic logic mode_is_low(input logic [1:0] mode);
        return (mode == MODE_LOW);
    endfunction

    function automatic logic mode_is_mod(input logic [1:0] mode);
        return (mode == MODE_MOD);
    endfunction

endpackage

// File: rtl/adc_pwr_seq_cnt.sv
// ---------------------------------------------------------------------------
// adc_pwr_seq_cnt
// Loadable saturating down-counter with a zero flag. A load takes priority
// over counting; otherwise the count decrements each cycle and holds at 0.
// Ports:
//   clk        in   system clock
//   clr        in   synchronous reset, active-high (count -> 0)
//   load_i     in   load load_val_i this cycle
//   load_val_i in   CNT_W value to load
//   cnt_o      out  current count
//   zero_o     out  count is zero
// ---------------------------------------------------------------------------
module adc_pwr_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adc_pwr_seq.sv
// ---------------------------------------------------------------------------
// adc_pwr_seq
// Power/conversion sequencer for the SAR ADC controller and its output
// register. Ramps the ADC power domain on demand, releases isolation/reset,
// issues single-cycle starts, waits for adc_done (DataMark) and then powers
// the domain down according to pwr_mode.
//
// Build option: define ADC_PWR_RET_EN to add retention save/restore
// (ret_save / ret_restore pulses, ret_valid tracking). Without it the
// retention outputs are tied 0 and RAMP->UNISO, POST->ISO directly.
//
// Ports:
//   clk          in   system clock
//   clr          in   synchronous reset, active-high
//   pwr_mode     in   2  00=LOW, 01=MODERATE, 1x=HIGH
//   conv_req     in   1-cycle conversion request
//   adc_done     in   conversion done from the ADC controller
//   conv_ack     out  1-cycle pulse coincident with adc_start
//   adc_start    out  1-cycle start to the ADC controller
//   adc_rst      out  ADC controller reset (follows iso_en)
//   pwr_en       out  ADC-domain power switch enable
//   iso_en       out  isolation enable (1 = isolated)
//   clk_en       out  ADC-domain clock-gate enable
//   ret_save     out  1-cycle retention save pulse
//   ret_restore  out  1-cycle retention restore pulse
//   busy         out  high in every state except OFF and IDLE
//   err          out  sticky conversion timeout flag
//   state_o      out  3  current state encoding
// ---------------------------------------------------------------------------
module adc_pwr_seq
    import adc_pwr_pkg::*;
#(
    parameter int PWR_UP_CYC = 8,
    parameter int ISO_CYC    = 2,
    parameter int IDLE_TMO   = 16,
    parameter int CONV_TMO   = 64,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] pwr_mode,
    input  logic       conv_req,
    input  logic       adc_done,
    output logic       conv_ack,
    output logic       adc_start,
    output logic       adc_rst,
    output logic       pwr_en,
    output logic       iso_en,
    output logic       clk_en,
    output logic       ret_save,
    output logic       ret_restore,
    output logic       busy,
    output logic       err,
    output logic [2:0] state_o
);

    state_e state_q, state_d;
    logic   pending_q, pending_d;
    logic   err_q, err_d;
    logic   conv_first_q, conv_first_d;

`ifdef ADC_PWR_RET_EN
    logic   ret_valid_q, ret_valid_d;
    logic   ret_dir_save_q, ret_dir_save_d;   // 1 = save (going down), 0 = restore
`endif

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt_cur;
    logic             cnt_zero;
    logic             start_now;
    logic             req_any;
    logic             go_down;

    // -----------------------------------------------------------------------
    // Shared timer
    // -----------------------------------------------------------------------
    adc_pwr_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .clr        (clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .cnt_o      (cnt_cur),
        .zero_o     (cnt_zero)
    );

    // A state lasting N cycles loads N-1 on entry and leaves when it hits 0.
    always_comb begin
        cnt_val = '0;
        case (state_d)
            ST_RAMP:          cnt_val = CNT_W'(PWR_UP_CYC - 1);
            ST_UNISO, ST_ISO: cnt_val = CNT_W'(ISO_CYC - 1);
            ST_IDLE:          cnt_val = CNT_W'(IDLE_TMO - 1);
            ST_CONV:          cnt_val = CNT_W'(CONV_TMO - 1);
            default:          cnt_val = '0;
        endcase
    end

    // Reload on every state entry. In IDLE the idle timer only runs while
    // the policy is MODERATE, so it is held at full scale otherwise; this
    // makes the timeout count consecutive MODERATE idle cycles.
    assign cnt_load = (state_d != state_q) ||
                      ((state_q == ST_IDLE) && (state_d == ST_IDLE) &&
                       !mode_is_mod(pwr_mode));

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    assign start_now = (state_q == ST_CONV) && conv_first_q;
    // A request arriving in the same cycle as a decision counts as pending,
    // so it beats an idle timeout or a LOW power-down.
    assign req_any   = pending_q || conv_req;

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        go_down      = 1'b0;
        // 1-deep request flag: cleared by the start, extra requests dropped
        pending_d    = start_now ? 1'b0 : (pending_q || conv_req);
`ifdef ADC_PWR_RET_EN
        ret_valid_d    = ret_valid_q;
        ret_dir_save_d = ret_dir_save_q;
`endif

        case (state_q)
            ST_OFF: begin
                if (req_any) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (cnt_zero) begin
`ifdef ADC_PWR_RET_EN
                    if (ret_valid_q) begin
                        state_d        = ST_RET;
                        ret_dir_save_d = 1'b0;
                    end else begin
                        state_d = ST_UNISO;
                    end
`else
                    state_d = ST_UNISO;
`endif
                end
            end
`ifdef ADC_PWR_RET_EN
            ST_RET: begin
                if (ret_dir_save_q) begin
                    state_d     = ST_ISO;
                    ret_valid_d = 1'b1;
                end else begin
                    state_d = ST_UNISO;
                end
            end
`endif
            ST_UNISO: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_CONV;
                end else if (mode_is_low(pwr_mode)) begin
                    go_down = 1'b1;
                end else if (mode_is_mod(pwr_mode) && cnt_zero) begin
                    go_down = 1'b1;
                end
            end
            ST_CONV: begin
                // done wins over a coincident timeout
                if (adc_done) begin
                    state_d = ST_POST;
                end else if (cnt_zero) begin
                    state_d = ST_POST;
                    err_d   = 1'b1;
                end
            end
            ST_POST: begin
                if (req_any) begin
                    state_d = ST_IDLE;
                end else if (mode_is_low(pwr_mode)) begin
                    go_down = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISO: begin
                if (cnt_zero) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        if (go_down) begin
`ifdef ADC_PWR_RET_EN
            state_d        = ST_RET;
            ret_dir_save_d = 1'b1;
`else
            state_d = ST_ISO;
`endif
        end

        conv_first_d = (state_d == ST_CONV) && (state_q != ST_CONV);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_OFF;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            conv_first_q <= 1'b0;
`ifdef ADC_PWR_RET_EN
            ret_valid_q    <= 1'b0;
            ret_dir_save_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
            conv_first_q <= conv_first_d;
`ifdef ADC_PWR_RET_EN
            ret_valid_q    <= ret_valid_d;
            ret_dir_save_q <= ret_dir_save_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from registered state)
    // -----------------------------------------------------------------------
    logic iso_c;

    always_comb begin
        iso_c = 1'b0;
        case (state_q)
            ST_OFF, ST_RAMP, ST_ISO: iso_c = 1'b1;
`ifdef ADC_PWR_RET_EN
            // restore runs before isolation release, save before isolation
            ST_RET:                  iso_c = !ret_dir_save_q;
`endif
            default:                 iso_c = 1'b0;
        endcase
    end

    assign iso_en    = iso_c;
    assign adc_rst   = iso_c;
    assign clk_en    = !iso_c;
    assign pwr_en    = (state_q != ST_OFF);
    assign busy      = (state_q != ST_OFF) && (state_q != ST_IDLE);
    assign adc_start = start_now;
    assign conv_ack  = start_now;
    assign err       = err_q;
    assign state_o   = state_q;

`ifdef ADC_PWR_RET_EN
    assign ret_save    = (state_q == ST_RET) && ret_dir_save_q;
    assign ret_restore = (state_q == ST_RET) && !ret_dir_save_q;
`else
    assign ret_save    = 1'b0;
    assign ret_restore = 1'b0;
`endif

    // count value is only consumed through the zero flag
    logic unused_cnt;
    assign unused_cnt = ^cnt_cur;

endmodule
